// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//
// Sequences a W-bit add or subtract (W = 4*NIBBLES) through one shared
// external 4-bit adder slice, one nibble per clock, LSB nibble first. The
// carry is chained between cycles through a register. The block assembles
// the wide result and reports the final carry and the signed overflow.
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE.
// There is no ready; a start seen in RUN or DONE is dropped. done pulses
// for exactly one cycle when result/cout/ovf are valid. result then holds
// until the next accepted start.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            request pulse, sampled in IDLE only
//   sub              0: op_a + op_b + cin, 1: op_a - op_b
//   op_a, op_b, cin  operands, latched together with start
//   busy             high while nibbles are being processed (RUN)
//   done             one-cycle result-valid pulse (DONE)
//   result           assembled W-bit sum, modulo 2^W
//   cout             final carry out (for subtract: 1 = no borrow)
//   ovf              signed two's-complement overflow
//   add_a, add_b     nibble operands to the shared adder (0 outside RUN)
//   add_cin          carry into the shared adder (0 outside RUN)
//   add_sum,add_cout combinational adder outputs for the current nibble
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic         add_cout
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry;
    logic [IW-1:0] idx;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;

    // Nibble select as an explicit mux so the index never leaves the
    // operand range, whatever NIBBLES is.
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        add_a      = 4'h0;
        add_b      = 4'h0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_nib;
                add_b   = b_nib;
                add_cin = carry;
                if (idx == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= op_a;
                        // Subtract is A + ~B + 1 through the same adder.
                        b_reg  <= sub ? ~op_b : op_b;
                        carry  <= sub ? 1'b1 : cin;
                        idx    <= '0;
                        result <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IW'(i)) result[4*i +: 4] <= add_sum;
                    end
                    carry <= add_cout;
                    if (idx == LAST) begin
                        idx  <= '0;
                        cout <= add_cout;
                        // Overflow: like-signed operands, result sign differs.
                        ovf  <= (a_reg[W-1] == b_reg[W-1]) &&
                                (add_sum[3] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl with NIBBLES=4. A behavioural 4-bit
// adder stands in for the shared slice. Expected results are pushed when an
// operation is issued and popped by a monitor when done is seen.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Shared 4-bit adder slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // {cout, ovf, result}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_exp;

    logic [W-1:0] seq_a;
    logic [3:0]   seq_cin;
    int           busy_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic c);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        logic         ov;
        bb   = s ? ~b : b;
        cc   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ov, full[W-1:0]};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
                check("result", 32'(result), 32'(last_exp[W-1:0]));
                check("cout", 32'(cout), 32'(last_exp[W+1]));
                check("ovf", 32'(ovf), 32'(last_exp[W]));
            end
        end
    end

    // Issue one operation starting at an IDLE negedge; return in the IDLE
    // cycle right after done. With disturb set, start is held high and the
    // operands scrambled throughout RUN and DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input logic disturb);
        int cycles;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        exp_q.push_back(model(a, b, s, c));
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cnt = 0;
        seq_a    = '0;
        seq_cin  = '0;
        cycles   = 0;
        while (!done && cycles < 20) begin
            if (busy && busy_cnt < NIBBLES) begin
                seq_a[4*busy_cnt +: 4] = add_a;
                seq_cin[busy_cnt]      = add_cin;
            end
            if (busy) busy_cnt++;
            if (disturb) begin
                start = 1'b1;
                op_a  = W'($urandom);
                op_b  = W'($urandom);
                sub   = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        check("done_timeout", 32'(cycles < 20), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(NIBBLES));
        check("add_a_seq", 32'(seq_a), 32'(a));
        check("busy_in_done", 32'(busy), 32'd0);
        check("add_a_idle", 32'({add_a, add_b, add_cin}), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'(model(a, b, s, c) & {2'b00, {W{1'b1}}}));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'({busy, done, cout, ovf, add_a, add_b, add_cin}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("cin_ripple_seq", 32'(seq_cin), 32'hF);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_op(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);

        // Start ignored in RUN/DONE; operands may change after acceptance
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        // Accepted in the first IDLE cycle after done
        run_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);

        // Reset during the second RUN cycle
        @(negedge clk);
        op_a  = 16'h1234;
        op_b  = 16'h1111;
        sub   = 1'b0;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", 32'({busy, done, cout, ovf, add_a, add_b, add_cin}), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs wide add/subtract by time-multiplexing one external 4-bit ripple adder slice (cong4bit: A, B, Cin -> Sum, Cout), one nibble per clock, LSB first.
- Sits between a requester issuing start/operands and the shared adder. Chains carry between cycles, assembles the wide result, and reports carry and signed overflow.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, cin forced 1); sampled with start
- op_a  input  W  operand A; sampled with start
- op_b  input  W  operand B; sampled with start
- cin  input  1  carry-in for add mode; sampled with start, ignored when sub=1
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when result is valid
- result  output  W  assembled sum; held stable from done until next accepted start
- cout  output  1  final carry out (for sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- add_a  output  4  to adder A
- add_b  output  4  to adder B
- add_cin  output  1  to adder Cin
- add_sum  input  4  from adder Sum (combinational, same cycle)
- add_cout  input  1  from adder Cout

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0, add_a=0, add_b=0, add_cin=0; internal regs cleared. Applies immediately, mid-operation included; the in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge: latch a_reg=op_a; b_reg=sub ? ~op_b : op_b; carry=sub ? 1 : cin; idx=0; result cleared to 0; -> RUN.
- IDLE, start=0: remain.
- RUN: combinationally drive add_a=a_reg[4*idx+3:4*idx], add_b=b_reg[same slice], add_cin=carry.
  - At each edge: result[slice idx]<=add_sum; carry<=add_cout; idx<=idx+1.
  - When idx==NIBBLES-1 at the edge: also cout<=add_cout; ovf<=(a_reg[W-1]==b_reg[W-1]) && (add_sum[3]!=a_reg[W-1]); -> DONE.
- DONE: done=1 for exactly one cycle; -> IDLE on the next edge.
- busy=1 in RUN only. add_a/add_b/add_cin are 0 outside RUN.
- Latency: start sampled at edge k; RUN cycles occupy k..k+NIBBLES; done is high during the cycle after edge k+NIBBLES. Total is NIBBLES+1 cycles from start sample to done.
- start while RUN or DONE: ignored, not queued. Earliest new start is sampled in the IDLE cycle after done, giving a throughput of one op per NIBBLES+2 cycles.
- Operand inputs may change freely after start is accepted; only the latched copies are used.
- Wrap-around: result is modulo 2^W; carry beyond the MSB appears only on cout.
- idx width is ceil(log2(NIBBLES)) bits, min 1. idx never exceeds NIBBLES-1.
- Adder Sum/Cout are treated as combinational within the cycle; no registering of the adder outputs.

Test Plan:
- NIBBLES=4, add: op_a=16'h0001, op_b=16'h0001, cin=0, start -> busy 4 cycles; done pulse; result=16'h0002, cout=0, ovf=0; add_a nibble sequence 1,0,0,0.
- Add with full carry ripple: op_a=16'hFFFF, op_b=16'h0000, cin=1 -> result=16'h0000, cout=1, ovf=0; add_cin sequence 1,1,1,1.
- Signed overflow: op_a=16'h7FFF, op_b=16'h0001, cin=0 -> result=16'h8000, cout=0, ovf=1. Then sub op_a=16'h8000, op_b=16'h0001 -> result=16'h7FFF, cout=1, ovf=1.
- Subtract with borrow: sub=1, op_a=16'h0003, op_b=16'h0005 -> result=16'hFFFE, cout=0, ovf=0. Also 16'h1234-16'h1234 -> 16'h0000, cout=1.
- Start while busy plus input change: issue 16'h00FF+16'h0001; pulse start with different operands and change op_a/op_b during RUN -> exactly one done; result=16'h0100; second start ignored. Start in the following IDLE cycle is accepted.
- Reset mid-operation: assert rst during the 2nd RUN cycle -> all outputs 0 immediately, no done pulse. After release, a new op 16'h1111+16'h2222 -> result=16'h3333 after 4 busy cycles.
